apb_req_master: RTL
===================

# apb_req_master

APB initiator that turns a simple valid/ready request/response interface into APB3 transfers. It drives one APB master port, normally into the slave port of the APB node, and gives local logic such as a debug module, DMA config engine or boot loader access to the peripheral space. Each transfer runs through an explicit IDLE/SETUP/ACCESS/RESP state machine. An optional timeout aborts a transfer whose slave never asserts PREADY.

## Interface
Parameters:
- APB_ADDR_WIDTH, 32, width of PADDR and req_addr_i
- APB_DATA_WIDTH, 32, width of PWDATA, PRDATA, req_wdata_i and rsp_rdata_o
- TIMEOUT_CYCLES, 255, number of ACCESS cycles with PREADY low before abort; must be ≥1; used only with the timeout feature

Ports:
- clk_i  in  1  clock; all logic rises on posedge
- rst_i  in  1  reset; one clock, synchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted while high with req_valid_i
- req_write_i  in  1  1 = write, 0 = read
- req_addr_i  in  APB_ADDR_WIDTH  transfer address
- req_wdata_i  in  APB_DATA_WIDTH  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  APB_DATA_WIDTH  read data; 0 for writes and for timeouts
- rsp_err_o  out  1  PSLVERR or timeout
- rsp_timeout_o  out  1  transfer was aborted by the timeout
- busy_o  out  1  state ≠ IDLE
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  APB_ADDR_WIDTH  APB address
- PWDATA  out  APB_DATA_WIDTH  APB write data
- PRDATA  in  APB_DATA_WIDTH  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

## Operation
- **IDLE:**
  - req_ready_o=1, PSEL=0, PENABLE=0.
  - On req_valid_i, register write, addr and wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
- **SETUP:** PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS.
- **ACCESS:**
  - PSEL=1, PENABLE=1.
  - On PREADY=1, capture the response:
    - rsp_rdata_o = PWRITE ? 0 : PRDATA
    - rsp_err_o = PSLVERR
    - rsp_timeout_o = 0
  - Then go to RESP.
  - While PREADY=0, stay in ACCESS.
- **RESP:**
  - rsp_valid_o=1, PSEL=0, PENABLE=0.
  - Go to IDLE when rsp_ready_i=1.
  - rsp_* outputs stay stable until that handshake.
- **Stable outputs:**
  - PADDR, PWRITE and PWDATA hold their captured values from SETUP through ACCESS.
  - They keep the last transfer's values in IDLE and RESP.
- **Inputs ignored outside their states:**
  - req_* inputs are ignored outside IDLE.
  - rsp_ready_i is ignored outside RESP.
  - PREADY, PRDATA and PSLVERR are ignored outside ACCESS.
- **Reset:**
  - Reset during any state forces IDLE on the next edge.
  - Any in-flight APB transfer is dropped without a response; rsp_valid_o goes to 0.
- **Reset values:** all outputs 0 except req_ready_o=1; the timeout counter is 0.

## Timing
- Request accepted at edge N (cycle 0) → SETUP in cycle 1 → ACCESS in cycle 2.
- PREADY=1 in cycle 2 gives rsp_valid_o=1 in cycle 3.
- With k wait states, rsp_valid_o rises in cycle 3+k.
- Minimum of 4 cycles per transfer (IDLE, SETUP, ACCESS, RESP). No back-to-back SETUP; the next request can be accepted one cycle after the response handshake.
- req_ready_o and rsp_valid_o are decoded from state only, with no combinational path from inputs.
- APB outputs are registered.

## Configuration
Macro: APB_REQ_MASTER_TIMEOUT_EN.
- **Defined:**
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on entry to ACCESS.
  - It increments every ACCESS cycle with PREADY=0.
  - When it equals TIMEOUT_CYCLES and PREADY is still 0, the next state is RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0. PSEL and PENABLE drop on that edge.
  - If PREADY=1 in the same cycle the limit is reached, the normal completion wins and no timeout is flagged.
- **Undefined:**
  - No counter is built; ACCESS waits indefinitely.
  - rsp_timeout_o is tied to 0.

## Test plan
- **Zero-wait write:** addr=0x1A10_0004, wdata=0xDEAD_BEEF, PREADY tied to 1 →
  - PSEL rises in cycle 1 and PENABLE only in cycle 2, with PADDR/PWDATA stable across both cycles.
  - rsp_valid_o=1 in cycle 3 with rsp_rdata_o=0 and rsp_err_o=0.
- **Read with 3 wait states:** PRDATA=0x1234_5678 presented with PREADY in the 4th ACCESS cycle → rsp_valid_o in cycle 6 with rsp_rdata_o=0x1234_5678.
- **Slave error plus response backpressure:**
  - PSLVERR=1 with PREADY, and rsp_ready_i held low for 5 cycles → rsp_err_o=1 held stable, req_ready_o=0 throughout.
  - The handshake returns the block to IDLE.
- **Timeout (macro defined, TIMEOUT_CYCLES=4):** PREADY held at 0 → PSEL/PENABLE drop after 4 ACCESS cycles, rsp_err_o=1, rsp_timeout_o=1.
  - Repeat with PREADY=1 exactly on the 4th ACCESS cycle → normal completion, rsp_timeout_o=0.
- **Reset mid-ACCESS:** rst_i=1 for one cycle during a wait state → next cycle PSEL=0, PENABLE=0, rsp_valid_o=0, req_ready_o=1.
  - A subsequent read completes normally.

Source files
------------

// File: rtl/apb_req_master.sv
// rtl/apb_req_master.sv - valid/ready request port to APB3 initiator bridge
//
// Purpose:
//   Converts single request/response handshakes into APB3 transfers through
//   an IDLE/SETUP/ACCESS/RESP state machine. Gives local logic (debug module,
//   DMA config engine, boot loader) access to the peripheral space.
//
// Optional feature (macro APB_REQ_MASTER_TIMEOUT_EN):
//   When defined, an ACCESS phase with PREADY low for TIMEOUT_CYCLES cycles
//   is aborted and answered with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
//   When undefined, ACCESS waits indefinitely and rsp_timeout_o is 0.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   request handshake (ready only in IDLE)
//   req_write_i/addr_i/wdata_i  request fields, captured on acceptance
//   rsp_valid_o/ready_i   response handshake (valid only in RESP)
//   rsp_rdata_o/err_o/timeout_o  response fields, stable while rsp_valid_o
//   busy_o                state is not IDLE
//   PSEL..PSLVERR         APB3 master port

module apb_req_master #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic                      busy_o,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [APB_DATA_WIDTH-1:0] PWDATA,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_done;
  logic   w_timeout;
  logic   w_to_hit;

  logic                      r_psel;
  logic                      r_penable;
  logic                      r_pwrite;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic [APB_DATA_WIDTH-1:0] r_rsp_rdata;
  logic                      r_rsp_err;

`ifdef APB_REQ_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_to_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_rsp_timeout;

  // The limit is judged on the count including the current wait cycle, so
  // the abort lands exactly after TIMEOUT_CYCLES ACCESS cycles.
  assign w_cnt_inc = r_to_cnt + 1'b1;
  assign w_to_hit  = !PREADY && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_to_cnt <= '0;
    end else if (r_state != S_ACCESS && w_state_next == S_ACCESS) begin
      r_to_cnt <= '0;
    end else if (r_state == S_ACCESS && !PREADY) begin
      r_to_cnt <= w_cnt_inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_timeout <= 1'b0;
    end else if (w_done) begin
      r_rsp_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_rsp_timeout <= 1'b1;
    end
  end

  assign rsp_timeout_o = r_rsp_timeout;
`else
  assign w_to_hit      = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid_i) w_state_next = S_SETUP;
      end
      S_SETUP: begin
        w_state_next = S_ACCESS;
      end
      S_ACCESS: begin
        // A PREADY on the limit cycle is a normal completion.
        if (PREADY) begin
          w_done       = 1'b1;
          w_state_next = S_RESP;
        end else if (w_to_hit) begin
          w_timeout    = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // APB strobes are registered from the next state so they change on the
  // same edge as the state without a decode after the flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_psel    <= (w_state_next == S_SETUP) || (w_state_next == S_ACCESS);
      r_penable <= (w_state_next == S_ACCESS);
      if (r_state == S_IDLE && req_valid_i) begin
        r_pwrite <= req_write_i;
        r_paddr  <= req_addr_i;
        r_pwdata <= req_wdata_i;
      end
      if (w_done) begin
        r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
        r_rsp_err   <= PSLVERR;
      end else if (w_timeout) begin
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b1;
      end
    end
  end

  assign req_ready_o = (r_state == S_IDLE);
  assign rsp_valid_o = (r_state == S_RESP);
  assign busy_o      = (r_state != S_IDLE);
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;

endmodule
